// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and related I/O arbiters.
package dmem_pkg;

  // Default abort limit for accesses that stay in a wait state too long
  localparam int WDOG_MAX_DEF = 64;

  // Arbiter FSM encodings
  localparam logic [2:0] ST_DRAIN     = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_RESP      = 3'd5;
  localparam logic [2:0] ST_ABORT     = 3'd6;

  // sign_mask bit positions understood by the memory
  localparam int MASK_SIGNED = 3;
  localparam int MASK_WORD   = 2;
  localparam int MASK_HALF   = 1;

  // Requester identity
  typedef enum logic {
    PORT0 = 1'b0,   // CPU load/store unit
    PORT1 = 1'b1    // debug/DMA loader
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Purely combinational; the caller owns last_grant.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  // A lone requester always wins; on contention the port that did not win last time goes
  always_comb begin
    valid = req0 | req1;
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store unit (port 0)
// and the debug/DMA loader (port 1). Each access is a one-cycle command pulse,
// followed by tracking the memory's clk_stall busy window, then an ack (or an
// err when the watchdog trips).
//
// state      | meaning
// DRAIN      | wait for any in-flight memory access to finish (after reset/abort)
// IDLE       | arbitrate between req0/req1, latch the winner's fields
// ISSUE      | single-cycle memread/memwrite strobe
// WAIT_BUSY  | wait for the memory to raise clk_stall
// WAIT_DONE  | wait for clk_stall to fall, capture read data
// RESP       | ack pulse to the granted port
// ABORT      | err pulse to the granted port, then drain
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0,
  input  logic              rd0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [3:0]        mask0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,

  input  logic              req1,
  input  logic              rd1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [3:0]        mask1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_sign_mask,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_clk_stall
);

  localparam int WDOG_W = $clog2(WDOG_MAX + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_MAX);

  logic [2:0]        state_q, state_d;
  port_e             grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [WDOG_W-1:0] wdog_inc;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              memread_q, memread_d, memwrite_q, memwrite_d;
  logic              abort;

  logic              arb_grant, arb_valid;
  logic              sel_rd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_mask;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // Fields of whichever port the arbiter currently favours
  always_comb begin
    sel_rd    = arb_grant ? rd1    : rd0;
    sel_addr  = arb_grant ? addr1  : addr0;
    sel_wdata = arb_grant ? wdata1 : wdata0;
    sel_mask  = arb_grant ? mask1  : mask0;
  end

  // Next-state, watchdog and response logic. Command strobes are registered so
  // they are high exactly for the ISSUE cycle; ack/err likewise for RESP/ABORT.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    wdog_d       = wdog_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    memread_d    = 1'b0;
    memwrite_d   = 1'b0;
    abort        = 1'b0;
    wdog_inc     = wdog_q + WDOG_W'(1);

    case (state_q)
      ST_DRAIN: begin
        wdog_d = '0;
        if (!mem_clk_stall) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (arb_valid) begin
          grant_d      = port_e'(arb_grant);
          last_grant_d = arb_grant;
          rd_d         = sel_rd;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          mask_d       = sel_mask;
          memread_d    = sel_rd;
          memwrite_d   = ~sel_rd;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (mem_clk_stall) begin
          state_d = ST_WAIT_DONE;
        end else begin
          wdog_d = wdog_inc;
          abort  = (wdog_inc == WDOG_LIM);
        end
      end

      ST_WAIT_DONE: begin
        if (!mem_clk_stall) begin
          state_d = ST_RESP;
          if (grant_q == PORT1) begin
            ack1_d = 1'b1;
            if (rd_q) rdata1_d = mem_read_data;
          end else begin
            ack0_d = 1'b1;
            if (rd_q) rdata0_d = mem_read_data;
          end
        end else begin
          wdog_d = wdog_inc;
          abort  = (wdog_inc == WDOG_LIM);
        end
      end

      ST_RESP: begin
        wdog_d  = '0;
        state_d = ST_IDLE;
      end

      ST_ABORT: begin
        wdog_d  = '0;
        state_d = ST_DRAIN;
      end

      default: begin
        state_d = ST_DRAIN;
      end
    endcase

    if (abort) begin
      state_d = ST_ABORT;
      if (grant_q == PORT1) err1_d = 1'b1;
      else                  err0_d = 1'b1;
    end
  end

  // Control state; reset lands in DRAIN so an access the memory is still
  // running (it has no reset) is allowed to finish before anything new issues
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_DRAIN;
      grant_q      <= PORT0;
      last_grant_q <= 1'b1;
      rd_q         <= 1'b0;
      wdog_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      wdog_q       <= wdog_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
    end
  end

  // Latched access fields; only meaningful while the strobe is high
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    mask_q  <= mask_d;
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign err0          = err0_q;
  assign err1          = err1_q;
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_sign_mask = mask_q;
  assign mem_memread   = memread_q;
  assign mem_memwrite  = memwrite_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory that stalls
// for two cycles after each command.
module tb_dmem_arbiter;

  localparam int WD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, rd0 = 1'b0, req1 = 1'b0, rd1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [3:0]  mask0 = '0, mask1 = '0;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_read_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread, mem_memwrite, mem_clk_stall;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WDOG_MAX(WD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .rd0(rd0), .addr0(addr0), .wdata0(wdata0), .mask0(mask0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .rd1(rd1), .addr1(addr1), .wdata1(wdata1), .mask1(mask1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sign_mask(mem_sign_mask),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );

  // Memory model: command seen at an edge -> stall high for two sampled edges,
  // read data (addr ^ key) presented as stall falls.
  logic        model_stall = 1'b0;
  logic        model_cnt = 1'b0;
  logic [31:0] model_rdata = '0, model_next = '0, model_key = '0;
  logic        force_stall = 1'b0, no_stall = 1'b0;

  assign mem_clk_stall = model_stall | force_stall;
  assign mem_read_data = model_rdata;

  always @(posedge clk) begin
    if ((mem_memread || mem_memwrite) && !no_stall) begin
      model_stall <= 1'b1;
      model_cnt   <= 1'b1;
      if (mem_memread) model_next <= mem_addr ^ model_key;
    end else if (model_stall) begin
      if (model_cnt == 1'b0) begin
        model_stall <= 1'b0;
        model_rdata <= model_next;
      end else begin
        model_cnt <= 1'b0;
      end
    end
  end

  // Bus monitor sampled on the falling edge
  int          rd_pulses = 0, wr_pulses = 0, strobe_viol = 0, overlap = 0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] wcap_addr = '0, wcap_wdata = '0, rcap_addr = '0;
  logic [3:0]  wcap_mask = '0, rcap_mask = '0;

  always @(negedge clk) begin
    if (mem_memread) begin
      rd_pulses = rd_pulses + 1;
      rcap_addr = mem_addr;
      rcap_mask = mem_sign_mask;
    end
    if (mem_memwrite) begin
      wr_pulses  = wr_pulses + 1;
      wcap_addr  = mem_addr;
      wcap_wdata = mem_wdata;
      wcap_mask  = mem_sign_mask;
    end
    if ((mem_memread && prev_rd) || (mem_memwrite && prev_wr) ||
        (mem_memread && mem_memwrite))
      strobe_viol = strobe_viol + 1;
    if ((int'(ack0) + int'(ack1) + int'(err0) + int'(err1)) > 1)
      overlap = overlap + 1;
    prev_rd = mem_memread;
    prev_wr = mem_memwrite;
  end

  // One complete access on a port; lat counts falling edges from the edge
  // that samples req (1 = ISSUE cycle) until ack or err is seen.
  task automatic run_access(input int port, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask,
                            output int lat, output logic got_ack, output logic got_err);
    @(negedge clk);
    if (port == 0) begin
      req0 = 1'b1; rd0 = rd; addr0 = addr; wdata0 = wdata; mask0 = mask;
    end else begin
      req1 = 1'b1; rd1 = rd; addr1 = addr; wdata1 = wdata; mask1 = mask;
    end
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat = lat + 1;
      if (port == 0 ? (ack0 || err0) : (ack1 || err1)) begin
        got_ack = (port == 0) ? ack0 : ack1;
        got_err = (port == 0) ? err0 : err1;
        break;
      end
    end
    if (port == 0) req0 = 1'b0;
    else           req1 = 1'b0;
  endtask

  task automatic test_reset;
    int r0;
    logic seen;
    rst_n = 1'b0; force_stall = 1'b1;
    req0 = 1'b1; rd0 = 1'b1; addr0 = 32'h40; mask0 = 4'b0100;
    repeat (2) @(negedge clk);
    total++;
    if ({ack0, ack1, err0, err1} !== 4'b0) begin
      bad++; $display("FAIL reset_ackerr got=%b want=0000", {ack0, ack1, err0, err1});
    end
    total++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", rdata0, rdata1);
    end
    total++;
    if ({mem_memread, mem_memwrite} !== 2'b00) begin
      bad++; $display("FAIL reset_strobes got=%b want=00", {mem_memread, mem_memwrite});
    end
    rst_n = 1'b1;
    r0 = rd_pulses;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (mem_memread !== 1'b0) begin
        bad++; $display("FAIL reset_drain_memread cyc=%0d got=%b want=0", i, mem_memread);
      end
    end
    force_stall = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack0) begin seen = 1'b1; break; end
    end
    req0 = 1'b0;
    total++;
    if (seen !== 1'b1) begin
      bad++; $display("FAIL reset_ack0 got=%b want=1", seen);
    end
    total++;
    if (rdata0 !== 32'h40) begin
      bad++; $display("FAIL reset_rdata0 got=%h want=00000040", rdata0);
    end
    repeat (3) @(negedge clk);
    total++;
    if (rd_pulses - r0 !== 1) begin
      bad++; $display("FAIL reset_read_pulses got=%0d want=1", rd_pulses - r0);
    end
  endtask

  task automatic test_read;
    int lat, r0;
    logic ga, ge;
    model_key = 32'hDEADBEEF ^ 32'h1004;
    r0 = rd_pulses;
    run_access(0, 1'b1, 32'h1004, 32'h0, 4'b0100, lat, ga, ge);
    total++;
    if (ga !== 1'b1 || ge !== 1'b0) begin
      bad++; $display("FAIL read_ack got=%b%b want=10", ga, ge);
    end
    total++;
    if (lat != 5) begin
      bad++; $display("FAIL read_latency got=%0d want=5", lat);
    end
    total++;
    if (rdata0 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL read_rdata0 got=%h want=deadbeef", rdata0);
    end
    @(negedge clk);
    total++;
    if (ack0 !== 1'b0) begin
      bad++; $display("FAIL read_ack_pulse got=%b want=0", ack0);
    end
    total++;
    if (rdata0 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL read_rdata_hold got=%h want=deadbeef", rdata0);
    end
    total++;
    if (rd_pulses - r0 !== 1) begin
      bad++; $display("FAIL read_pulses got=%0d want=1", rd_pulses - r0);
    end
    total++;
    if (rcap_addr !== 32'h1004 || rcap_mask !== 4'b0100) begin
      bad++; $display("FAIL read_bus got=%h/%b want=00001004/0100", rcap_addr, rcap_mask);
    end
  endtask

  task automatic test_write;
    int lat, r0, w0;
    logic ga, ge;
    model_key = 32'h0;
    run_access(1, 1'b1, 32'h300, 32'h0, 4'b0100, lat, ga, ge);
    total++;
    if (ga !== 1'b1 || lat != 5 || rdata1 !== 32'h300) begin
      bad++; $display("FAIL write_preread got=ack%b lat%0d %h want=ack1 lat5 00000300", ga, lat, rdata1);
    end
    r0 = rd_pulses; w0 = wr_pulses;
    run_access(1, 1'b0, 32'h2000, 32'h000000A5, 4'b0000, lat, ga, ge);
    total++;
    if (ga !== 1'b1 || ge !== 1'b0 || lat != 5) begin
      bad++; $display("FAIL write_ack got=ack%b err%b lat%0d want=ack1 err0 lat5", ga, ge, lat);
    end
    total++;
    if (wcap_addr !== 32'h2000 || wcap_wdata !== 32'hA5 || wcap_mask !== 4'b0000) begin
      bad++; $display("FAIL write_bus got=%h/%h/%b want=00002000/000000a5/0000", wcap_addr, wcap_wdata, wcap_mask);
    end
    total++;
    if (wr_pulses - w0 !== 1 || rd_pulses - r0 !== 0) begin
      bad++; $display("FAIL write_pulses got=wr%0d rd%0d want=wr1 rd0", wr_pulses - w0, rd_pulses - r0);
    end
    total++;
    if (rdata1 !== 32'h300) begin
      bad++; $display("FAIL write_rdata1 got=%h want=00000300", rdata1);
    end
  endtask

  task automatic test_round_robin;
    int seq[4];
    int n, r0;
    model_key = 32'h0;
    r0 = rd_pulses;
    n = 0;
    @(negedge clk);
    req0 = 1'b1; rd0 = 1'b1; addr0 = 32'h100; mask0 = 4'b0100;
    req1 = 1'b1; rd1 = 1'b1; addr1 = 32'h200; mask1 = 4'b0100;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack0) begin seq[n] = 0; n++; end
      else if (ack1) begin seq[n] = 1; n++; end
      if (n == 4) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (n != 4) begin
      bad++; $display("FAIL rr_count got=%0d want=4", n);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i < n && seq[i] != (i % 2)) begin
        bad++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, seq[i], i % 2);
      end
    end
    total++;
    if (rd_pulses - r0 !== 4) begin
      bad++; $display("FAIL rr_issued got=%0d want=4", rd_pulses - r0);
    end
    total++;
    if (rdata0 !== 32'h100 || rdata1 !== 32'h200) begin
      bad++; $display("FAIL rr_rdata got=%h/%h want=00000100/00000200", rdata0, rdata1);
    end
  endtask

  task automatic test_watchdog;
    int lat;
    logic ga, ge;
    no_stall = 1'b1;
    run_access(0, 1'b1, 32'h80, 32'h0, 4'b0100, lat, ga, ge);
    total++;
    if (ge !== 1'b1 || ga !== 1'b0) begin
      bad++; $display("FAIL wdog_err got=err%b ack%b want=err1 ack0", ge, ga);
    end
    total++;
    if (lat != WD + 2) begin
      bad++; $display("FAIL wdog_latency got=%0d want=%0d", lat, WD + 2);
    end
    @(negedge clk);
    total++;
    if (err0 !== 1'b0) begin
      bad++; $display("FAIL wdog_err_pulse got=%b want=0", err0);
    end
    no_stall = 1'b0;
    model_key = 32'h0;
    run_access(0, 1'b1, 32'h84, 32'h0, 4'b0100, lat, ga, ge);
    total++;
    if (ga !== 1'b1 || lat != 5 || rdata0 !== 32'h84) begin
      bad++; $display("FAIL wdog_recover got=ack%b lat%0d %h want=ack1 lat5 00000084", ga, lat, rdata0);
    end
  endtask

  task automatic test_reset_mid_access;
    int lat, r0;
    logic ga, ge, stray;
    model_key = 32'h0;
    @(negedge clk);
    req0 = 1'b1; rd0 = 1'b1; addr0 = 32'h88; mask0 = 4'b0100;
    repeat (3) @(negedge clk);
    req0 = 1'b0; force_stall = 1'b1; rst_n = 1'b0;
    r0 = rd_pulses;
    stray = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ack0, err0} !== 2'b00 || rdata0 !== 32'h0) begin
      bad++; $display("FAIL midrst_state got=%b%b %h want=00 00000000", ack0, err0, rdata0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({ack0, ack1, err0, err1, mem_memread, mem_memwrite} !== 6'b0) begin
        bad++; $display("FAIL midrst_drain cyc=%0d got=%b want=000000", i,
                        {ack0, ack1, err0, err1, mem_memread, mem_memwrite});
      end
    end
    force_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack0 || ack1 || err0 || err1) stray = 1'b1;
    end
    total++;
    if (stray !== 1'b0 || rd_pulses - r0 !== 0) begin
      bad++; $display("FAIL midrst_stray got=%b pulses%0d want=0 pulses0", stray, rd_pulses - r0);
    end
    run_access(0, 1'b1, 32'h90, 32'h0, 4'b0100, lat, ga, ge);
    total++;
    if (ga !== 1'b1 || lat != 5 || rdata0 !== 32'h90) begin
      bad++; $display("FAIL midrst_next got=ack%b lat%0d %h want=ack1 lat5 00000090", ga, lat, rdata0);
    end
  endtask

  task automatic test_bus_rules;
    total++;
    if (overlap != 0) begin
      bad++; $display("FAIL ack_exclusive got=%0d want=0", overlap);
    end
    total++;
    if (strobe_viol != 0) begin
      bad++; $display("FAIL strobe_width got=%0d want=0", strobe_viol);
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_round_robin;
    test_watchdog;
    test_reset_mid_access;
    test_bus_rules;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
